ps2_key_event_decoder: RTL and testbench
========================================

Name: ps2_key_event_decoder

Overview:
Parametrised successor to the single-byte scan-code converter. Consumes raw PS/2 Set-2 bytes from the PS/2 receiver and decodes them into complete key events. Handles E0 extended prefixes, F0 break sequences and the E1 Pause sequence, tracks modifier and caps-lock state, and suppresses typematic repeats. Events are queued in a FIFO with a valid/ready handshake to the host-side ASCII/CPU interface.

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of two, 2..64
REPORT_RELEASE, 1, 1 = push break events; 0 = drop them, but still update modifier and repeat state
REPORT_MODIFIERS, 0, 1 = push events for modifier keys themselves; 0 = update state only
SUPPRESS_REPEAT, 1, 1 = drop repeated makes of the held key

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-high
scan_in  in  8  byte from PS/2 receiver
scan_valid  in  1  one-cycle strobe; scan_in is valid this cycle
evt_ready  in  1  consumer accepts the head event
ovf_clr  in  1  clears overflow
evt_valid  out  1  FIFO non-empty
evt_code  out  8  Set-2 code, without prefixes
evt_ext  out  1  code was E0-prefixed
evt_release  out  1  break event
evt_mods  out  4  {caps, alt, ctrl, shift}, snapshot taken after this byte was processed
fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy
overflow  out  1  sticky; an event was dropped because the FIFO was full
caps_led  out  1  current caps-lock toggle state

Behaviour:
- Reset: clk is the clock; reset is asynchronous and active-high. All outputs go to 0, FSM goes to IDLE, FIFO empties, all modifier bits clear, last_make is cleared.
- An asserted reset mid-sequence abandons any partial prefix; no event is produced.
- FSM states, each advanced only on scan_valid:
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - E1 -> SKIP with skip_cnt=7.
    - AA, FA, FE, EE, 00, FF: dropped, stay in IDLE.
    - Any other byte: make(code, ext=0), stay in IDLE.
  - EXT:
    - F0 -> EXT_BRK.
    - Any other byte: make(code, ext=1) -> IDLE.
  - BRK: any byte: break(code, ext=0) -> IDLE.
  - EXT_BRK: any byte: break(code, ext=1) -> IDLE.
  - SKIP: decrement skip_cnt on each byte. At 0 -> IDLE and push a make event code=0x77, ext=1 (Pause). Pause never produces a break event.
- Modifiers:
  - Held bits are tracked separately: lshift 12, rshift 59, lctrl 14, rctrl E0 14, lalt 11, ralt E0 11.
  - shift = lshift|rshift; ctrl and alt are ORed the same way.
  - Caps (58, ext=0) toggles caps on a non-suppressed make only.
  - Fake shifts (E0 12, E0 59, make or break) are dropped entirely and do not affect state.
- Repeat suppression:
  - last_make = {ext, code} of the most recent accepted make.
  - A make equal to last_make is dropped when SUPPRESS_REPEAT=1.
  - A break matching last_make clears it. Any other make replaces it.
- Modifier events are pushed only if REPORT_MODIFIERS=1. Break events are pushed only if REPORT_RELEASE=1.
- Latency: byte completing an event on scan_valid at cycle N -> pushed at the N edge -> evt_valid=1 at cycle N+1 (FIFO previously empty).
- FIFO behaviour:
  - First-word-fall-through. Pop occurs when evt_valid && evt_ready.
  - Push while full with no simultaneous pop: event dropped, overflow set.
  - Push while full with a simultaneous pop: accepted, level unchanged.
  - Pop while empty: ignored.
- Overflow: ovf_clr clears overflow. If ovf_clr and a new overflow occur in the same cycle, overflow stays set.
- Width: pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Level saturates at FIFO_DEPTH.

Decomposition:
- Package ps2_pkg holds:
  - code constants: BREAK F0, EXT E0, PAUSE E1, the 6 modifier codes, CAPS, the reply codes;
  - the FSM state enum {IDLE, EXT, BRK, EXT_BRK, SKIP};
  - typedef key_evt_t {ext, release, mods[3:0], code[7:0]} (14 bits).
- One sub-module: key_event_fifo, parametrised on DEPTH and the key_evt_t width. It provides valid/ready, level and full.

Test Plan:
- 1C, then F0 1C -> events {1C, ext0, rel0, mods 0}, {1C, rel1}; evt_valid rises one cycle after each completing byte.
- 12, 1C, F0 1C, F0 12 (REPORT_MODIFIERS=0) -> two events with mods=0001; after the final F0 12, shift=0 and no further events.
- E0 75, E0 F0 75 -> make and break with ext=1, code 75. E0 12 E0 7C -> only {7C, ext1}; shift stays 0.
- 1C, 1C, 1C, F0 1C (SUPPRESS_REPEAT=1) -> exactly 1 make + 1 break. The same sequence with the parameter at 0 -> 3 makes + 1 break.
- E1 14 77 E1 F0 14 F0 77 -> single event {77, ext1, rel0}. 58, F0 58, 58 -> caps_led goes 1 then 0.
- evt_ready=0 and 10 makes with FIFO_DEPTH=8 -> level=8, overflow=1, first 8 codes preserved in order. Then push and pop in the same full cycle -> level stays 8. Reset asserted between E0 and the next byte -> no event, FSM in IDLE.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 Set-2 key event decoder: byte codes,
// decoder states and the queued key event record.
package ps2_pkg;

    localparam logic [7:0] CODE_BREAK     = 8'hF0;
    localparam logic [7:0] CODE_EXT       = 8'hE0;
    localparam logic [7:0] CODE_PAUSE     = 8'hE1;

    localparam logic [7:0] CODE_LSHIFT    = 8'h12;
    localparam logic [7:0] CODE_RSHIFT    = 8'h59;
    localparam logic [7:0] CODE_LCTRL     = 8'h14;
    localparam logic [7:0] CODE_RCTRL     = 8'h14;
    localparam logic [7:0] CODE_LALT      = 8'h11;
    localparam logic [7:0] CODE_RALT      = 8'h11;
    localparam logic [7:0] CODE_CAPS      = 8'h58;
    localparam logic [7:0] CODE_PAUSE_KEY = 8'h77;

    localparam logic [7:0] CODE_BAT       = 8'hAA;
    localparam logic [7:0] CODE_ACK       = 8'hFA;
    localparam logic [7:0] CODE_RESEND    = 8'hFE;
    localparam logic [7:0] CODE_ECHO      = 8'hEE;
    localparam logic [7:0] CODE_ERR0      = 8'h00;
    localparam logic [7:0] CODE_ERR1      = 8'hFF;

    // Bytes that follow E1 in the Pause make sequence.
    localparam logic [2:0] PAUSE_SKIP_LEN = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK,
        SKIP
    } ps2_state_t;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [3:0] mods;
        logic [7:0] code;
    } key_evt_t;

    localparam int KEY_EVT_W = $bits(key_evt_t);

    function automatic logic is_reply(input logic [7:0] b);
        return (b == CODE_BAT) || (b == CODE_ACK) || (b == CODE_RESEND) ||
               (b == CODE_ECHO) || (b == CODE_ERR0) || (b == CODE_ERR1);
    endfunction

    // Held-key bit order: lshift, rshift, lctrl, rctrl, lalt, ralt.
    function automatic logic [5:0] mod_mask(input logic ext, input logic [7:0] code);
        logic [5:0] m;
        m    = '0;
        m[0] = !ext && (code == CODE_LSHIFT);
        m[1] = !ext && (code == CODE_RSHIFT);
        m[2] = !ext && (code == CODE_LCTRL);
        m[3] =  ext && (code == CODE_RCTRL);
        m[4] = !ext && (code == CODE_LALT);
        m[5] =  ext && (code == CODE_RALT);
        return m;
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// First-word-fall-through event queue with valid/ready pop side.
// A push while full is accepted only when a pop happens in the same cycle.
module key_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 14,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [AW:0]      level,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             pop;
    logic             accept;

    assign valid  = (count != '0);
    assign full   = (count == (AW+1)'(DEPTH));
    assign pop    = valid && ready;
    assign accept = push && (!full || pop);
    assign level  = count;
    assign data   = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({accept, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the output is masked while empty.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// Turns raw PS/2 Set-2 bytes into key events with modifier/caps tracking
// and typematic repeat suppression, queued for the host interface.
//
// state   | meaning
// IDLE    | waiting for the first byte of a sequence
// EXT     | E0 seen
// BRK     | F0 seen
// EXT_BRK | E0 F0 seen
// SKIP    | swallowing the remainder of the E1 Pause sequence
module ps2_key_event_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH       = 8,
    parameter int REPORT_RELEASE   = 1,
    parameter int REPORT_MODIFIERS = 0,
    parameter int SUPPRESS_REPEAT  = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    scan_in,
    input  logic                          scan_valid,
    input  logic                          evt_ready,
    input  logic                          ovf_clr,
    output logic                          evt_valid,
    output logic [7:0]                    evt_code,
    output logic                          evt_ext,
    output logic                          evt_release,
    output logic [3:0]                    evt_mods,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          caps_led
);

    ps2_state_t state, state_n;
    logic [2:0] skip_cnt, skip_n;
    logic [5:0] held, held_n;
    logic       caps, caps_n;
    logic [8:0] last_make, last_n;

    logic       key_valid;
    logic       key_ext;
    logic       key_rel;
    logic       pause_done;

    logic       push;
    key_evt_t   push_evt;
    key_evt_t   head;
    logic [KEY_EVT_W-1:0] head_bits;
    logic       fifo_full;
    logic       drop;

    always_comb begin
        state_n    = state;
        skip_n     = skip_cnt;
        key_valid  = 1'b0;
        key_ext    = 1'b0;
        key_rel    = 1'b0;
        pause_done = 1'b0;
        if (scan_valid) begin
            case (state)
                IDLE: begin
                    if (scan_in == CODE_EXT) begin
                        state_n = EXT;
                    end else if (scan_in == CODE_BREAK) begin
                        state_n = BRK;
                    end else if (scan_in == CODE_PAUSE) begin
                        state_n = SKIP;
                        skip_n  = PAUSE_SKIP_LEN;
                    end else if (!is_reply(scan_in)) begin
                        key_valid = 1'b1;
                    end
                end
                EXT: begin
                    if (scan_in == CODE_BREAK) begin
                        state_n = EXT_BRK;
                    end else begin
                        key_valid = 1'b1;
                        key_ext   = 1'b1;
                        state_n   = IDLE;
                    end
                end
                BRK: begin
                    key_valid = 1'b1;
                    key_rel   = 1'b1;
                    state_n   = IDLE;
                end
                EXT_BRK: begin
                    key_valid = 1'b1;
                    key_ext   = 1'b1;
                    key_rel   = 1'b1;
                    state_n   = IDLE;
                end
                SKIP: begin
                    skip_n = skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1) begin
                        pause_done = 1'b1;
                        state_n    = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    logic [5:0] key_mods;
    logic [8:0] key_id;
    logic       is_mod;
    logic       is_fake;

    assign key_mods = mod_mask(key_ext, scan_in);
    assign key_id   = {key_ext, scan_in};
    assign is_mod   = |key_mods;
    assign is_fake  = key_ext && ((scan_in == CODE_LSHIFT) || (scan_in == CODE_RSHIFT));

    // Pause bypasses repeat tracking: it has no break to clear last_make.
    always_comb begin
        held_n   = held;
        caps_n   = caps;
        last_n   = last_make;
        push     = 1'b0;
        push_evt = '0;
        if (pause_done) begin
            push = 1'b1;
        end else if (key_valid && !is_fake) begin
            if (!key_rel) begin
                if (!((SUPPRESS_REPEAT != 0) && (key_id == last_make))) begin
                    last_n = key_id;
                    held_n = held | key_mods;
                    if (key_id == {1'b0, CODE_CAPS}) begin
                        caps_n = !caps;
                    end
                    push = !is_mod || (REPORT_MODIFIERS != 0);
                end
            end else begin
                held_n = held & ~key_mods;
                if (key_id == last_make) begin
                    last_n = '0;
                end
                push = (REPORT_RELEASE != 0) && (!is_mod || (REPORT_MODIFIERS != 0));
            end
        end
        push_evt.ext  = pause_done ? 1'b1 : key_ext;
        push_evt.rel  = pause_done ? 1'b0 : key_rel;
        push_evt.code = pause_done ? CODE_PAUSE_KEY : scan_in;
        push_evt.mods = {caps_n, held_n[4] | held_n[5], held_n[2] | held_n[3],
                         held_n[0] | held_n[1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    assign drop = push && fifo_full && !(evt_valid && evt_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skip_cnt  <= '0;
            held      <= '0;
            caps      <= 1'b0;
            last_make <= '0;
            overflow  <= 1'b0;
        end else begin
            skip_cnt  <= skip_n;
            held      <= held_n;
            caps      <= caps_n;
            last_make <= last_n;
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    key_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (KEY_EVT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_evt),
        .ready     (evt_ready),
        .valid     (evt_valid),
        .data      (head_bits),
        .level     (fifo_level),
        .full      (fifo_full)
    );

    assign head        = key_evt_t'(head_bits);
    assign evt_code    = head.code;
    assign evt_ext     = head.ext;
    assign evt_release = head.rel;
    assign evt_mods    = head.mods;
    assign caps_led    = caps;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Bench for the PS/2 key event decoder: two parameterisations driven by the
// same byte stream, each checked every cycle against a sequence-level model.
module tb_ps2_key_event_decoder;

    localparam int DEPTH_A = 8;
    localparam int DEPTH_B = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] scan_in = 8'h00;
    logic       scan_valid = 1'b0;
    logic       evt_ready = 1'b0;
    logic       ovf_clr = 1'b0;

    logic       valid_a, ext_a, rel_a, ovf_a, caps_a;
    logic [7:0] code_a;
    logic [3:0] mods_a;
    logic [3:0] level_a;
    logic       valid_b, ext_b, rel_b, ovf_b, caps_b;
    logic [7:0] code_b;
    logic [3:0] mods_b;
    logic [2:0] level_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #10 clk = ~clk;

    ps2_key_event_decoder #(
        .FIFO_DEPTH(DEPTH_A), .REPORT_RELEASE(1), .REPORT_MODIFIERS(0), .SUPPRESS_REPEAT(1)
    ) dut (
        .clk(clk), .reset(reset), .scan_in(scan_in), .scan_valid(scan_valid),
        .evt_ready(evt_ready), .ovf_clr(ovf_clr), .evt_valid(valid_a),
        .evt_code(code_a), .evt_ext(ext_a), .evt_release(rel_a), .evt_mods(mods_a),
        .fifo_level(level_a), .overflow(ovf_a), .caps_led(caps_a)
    );

    ps2_key_event_decoder #(
        .FIFO_DEPTH(DEPTH_B), .REPORT_RELEASE(1), .REPORT_MODIFIERS(1), .SUPPRESS_REPEAT(0)
    ) dut_b (
        .clk(clk), .reset(reset), .scan_in(scan_in), .scan_valid(scan_valid),
        .evt_ready(evt_ready), .ovf_clr(ovf_clr), .evt_valid(valid_b),
        .evt_code(code_b), .evt_ext(ext_b), .evt_release(rel_b), .evt_mods(mods_b),
        .fifo_level(level_b), .overflow(ovf_b), .caps_led(caps_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: events as {ext, rel, mods[3:0], code[7:0]} ----------------
    logic [7:0]  seq[$];
    logic [13:0] mq0[$];
    logic [13:0] mq1[$];
    logic [5:0]  m_held[2];
    logic        m_caps[2];
    logic [8:0]  m_last[2];
    logic        m_ovf[2];
    int          p_depth[2]  = '{DEPTH_A, DEPTH_B};
    bit          p_sup[2]    = '{1'b1, 1'b0};
    bit          p_repmod[2] = '{1'b0, 1'b1};
    bit          p_reprel[2] = '{1'b1, 1'b1};

    function automatic int mod_index(input logic [8:0] key);
        case (key)
            9'h012:  return 0;
            9'h059:  return 1;
            9'h014:  return 2;
            9'h114:  return 3;
            9'h011:  return 4;
            9'h111:  return 5;
            default: return -1;
        endcase
    endfunction

    function automatic logic [3:0] mods_of(input int i);
        logic [5:0] h;
        h = m_held[i];
        return {m_caps[i], h[4] | h[5], h[2] | h[3], h[0] | h[1]};
    endfunction

    task automatic apply_key(input int i, input logic ext, input logic rel, input logic [7:0] code,
                             output bit push, output logic [13:0] ev);
        logic [8:0] key;
        int mi;
        key  = {ext, code};
        mi   = mod_index(key);
        push = 1'b0;
        if (key != 9'h112 && key != 9'h159) begin
            if (!rel) begin
                if (!(p_sup[i] && key == m_last[i])) begin
                    m_last[i] = key;
                    if (mi >= 0) m_held[i][mi] = 1'b1;
                    if (key == 9'h058) m_caps[i] = ~m_caps[i];
                    push = (mi < 0) || p_repmod[i];
                end
            end else begin
                if (mi >= 0) m_held[i][mi] = 1'b0;
                if (key == m_last[i]) m_last[i] = '0;
                push = p_reprel[i] && ((mi < 0) || p_repmod[i]);
            end
        end
        ev = {ext, rel, mods_of(i), code};
    endtask

    bit          have_key, have_pause, do_pop0, do_pop1, push_i;
    logic        k_ext, k_rel;
    logic [7:0]  k_code;
    logic [13:0] ev_i;
    int          qsz;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            seq.delete();
            mq0.delete();
            mq1.delete();
            for (int i = 0; i < 2; i++) begin
                m_held[i] = '0; m_caps[i] = 1'b0; m_last[i] = '0; m_ovf[i] = 1'b0;
            end
        end else begin
            do_pop0 = (mq0.size() > 0) && evt_ready;
            do_pop1 = (mq1.size() > 0) && evt_ready;
            have_key = 1'b0;
            have_pause = 1'b0;
            if (scan_valid) begin
                seq.push_back(scan_in);
                if (seq[0] == 8'hE1) begin
                    if (seq.size() == 8) begin
                        have_pause = 1'b1;
                        seq.delete();
                    end
                end else if (seq.size() == 1 && (scan_in == 8'hE0 || scan_in == 8'hF0)) begin
                end else if (seq.size() == 2 && seq[0] == 8'hE0 && scan_in == 8'hF0) begin
                end else begin
                    k_ext  = (seq[0] == 8'hE0);
                    k_rel  = (seq[0] == 8'hF0) || (seq.size() == 3);
                    k_code = scan_in;
                    have_key = !(seq.size() == 1 && (scan_in inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}));
                    seq.delete();
                end
            end
            for (int i = 0; i < 2; i++) begin
                push_i = 1'b0;
                ev_i = '0;
                if (have_pause) begin
                    push_i = 1'b1;
                    ev_i = {1'b1, 1'b0, mods_of(i), 8'h77};
                end else if (have_key) begin
                    apply_key(i, k_ext, k_rel, k_code, push_i, ev_i);
                end
                if (i == 0) begin
                    if (do_pop0) void'(mq0.pop_front());
                    qsz = mq0.size();
                    if (push_i && qsz < p_depth[0]) mq0.push_back(ev_i);
                end else begin
                    if (do_pop1) void'(mq1.pop_front());
                    qsz = mq1.size();
                    if (push_i && qsz < p_depth[1]) mq1.push_back(ev_i);
                end
                if (push_i && qsz >= p_depth[i]) m_ovf[i] = 1'b1;
                else if (ovf_clr) m_ovf[i] = 1'b0;
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("valid_a", 32'(valid_a), 32'(mq0.size() != 0));
        chk("level_a", 32'(level_a), 32'(mq0.size()));
        chk("ovf_a",   32'(ovf_a),   32'(m_ovf[0]));
        chk("caps_a",  32'(caps_a),  32'(m_caps[0]));
        if (mq0.size() != 0) chk("head_a", 32'({ext_a, rel_a, mods_a, code_a}), 32'(mq0[0]));
        chk("valid_b", 32'(valid_b), 32'(mq1.size() != 0));
        chk("level_b", 32'(level_b), 32'(mq1.size()));
        chk("ovf_b",   32'(ovf_b),   32'(m_ovf[1]));
        chk("caps_b",  32'(caps_b),  32'(m_caps[1]));
        if (mq1.size() != 0) chk("head_b", 32'({ext_b, rel_b, mods_b, code_b}), 32'(mq1[0]));
    end

    // ---------------- stimulus ----------------
    task automatic send_x(input logic [7:0] b, input logic rdy, input logic clr);
        @(posedge clk); #1;
        scan_in = b; scan_valid = 1'b1; evt_ready = rdy; ovf_clr = clr;
        @(posedge clk); #1;
        scan_valid = 1'b0; evt_ready = 1'b0; ovf_clr = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        send_x(b, 1'b0, 1'b0);
    endtask

    task automatic expect_head(input string name, input logic [7:0] code, input logic ext,
                               input logic rel, input logic [3:0] mods);
        chk({name, "_valid"}, 32'(valid_a), 32'd1);
        chk(name, 32'({ext_a, rel_a, mods_a, code_a}), 32'({ext, rel, mods, code}));
    endtask

    task automatic pop1();
        @(posedge clk); #1; evt_ready = 1'b1;
        @(posedge clk); #1; evt_ready = 1'b0;
    endtask

    task automatic drain();
        int k;
        @(posedge clk); #1; evt_ready = 1'b1;
        for (k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            if (!valid_a && !valid_b) break;
        end
        evt_ready = 1'b0;
        chk("drain_empty", 32'(valid_a | valid_b), 32'd0);
        ovf_clr = 1'b1;
        @(posedge clk); #1; ovf_clr = 1'b0;
    endtask

    logic [7:0] fill_codes[10] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D};
    logic [7:0] kept_codes[8]  = '{8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h4B};
    logic [7:0] pause_seq[8]   = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    initial begin
        repeat (3) @(posedge clk);
        #5 reset = 1'b0;
        @(posedge clk); #1;
        chk("reset_valid", 32'(valid_a), 32'd0);
        chk("reset_level", 32'(level_a), 32'd0);

        // single make, then break
        send(8'h1C);
        expect_head("make_1c", 8'h1C, 1'b0, 1'b0, 4'b0000);
        send(8'hF0); send(8'h1C);
        chk("make_brk_level", 32'(level_a), 32'd2);
        pop1();
        expect_head("brk_1c", 8'h1C, 1'b0, 1'b1, 4'b0000);
        drain();

        // shift held around a key
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
        chk("shift_level", 32'(level_a), 32'd2);
        chk("shift_level_b", 32'(level_b), 32'd4);
        expect_head("shift_make", 8'h1C, 1'b0, 1'b0, 4'b0001);
        pop1();
        expect_head("shift_brk", 8'h1C, 1'b0, 1'b1, 4'b0001);
        drain();

        // extended keys and fake shift
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        expect_head("ext_make", 8'h75, 1'b1, 1'b0, 4'b0000);
        pop1();
        expect_head("ext_brk", 8'h75, 1'b1, 1'b1, 4'b0000);
        pop1();
        send(8'hE0); send(8'h12); send(8'hE0); send(8'h7C);
        chk("fake_level", 32'(level_a), 32'd1);
        expect_head("fake_shift", 8'h7C, 1'b1, 1'b0, 4'b0000);
        drain();

        // typematic repeats
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
        chk("repeat_sup_level", 32'(level_a), 32'd2);
        chk("repeat_nosup_level", 32'(level_b), 32'd4);
        drain();

        // pause
        for (int i = 0; i < 8; i++) send(pause_seq[i]);
        chk("pause_level", 32'(level_a), 32'd1);
        expect_head("pause", 8'h77, 1'b1, 1'b0, 4'b0000);
        drain();

        // caps toggle
        send(8'h58);
        chk("caps_on", 32'(caps_a), 32'd1);
        expect_head("caps_make", 8'h58, 1'b0, 1'b0, 4'b1000);
        send(8'hF0); send(8'h58);
        chk("caps_hold", 32'(caps_a), 32'd1);
        send(8'h58);
        chk("caps_off", 32'(caps_a), 32'd0);
        drain();

        // overflow and full-cycle push/pop
        for (int i = 0; i < 10; i++) send(fill_codes[i]);
        chk("full_level", 32'(level_a), 32'd8);
        chk("full_ovf", 32'(ovf_a), 32'd1);
        expect_head("full_head", 8'h15, 1'b0, 1'b0, 4'b0000);
        send_x(8'h4C, 1'b0, 1'b1);
        chk("ovf_set_wins", 32'(ovf_a), 32'd1);
        @(posedge clk); #1; ovf_clr = 1'b1;
        @(posedge clk); #1; ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(ovf_a), 32'd0);
        send_x(8'h4B, 1'b1, 1'b0);
        chk("pushpop_level", 32'(level_a), 32'd8);
        chk("pushpop_ovf", 32'(ovf_a), 32'd0);
        for (int i = 0; i < 8; i++) begin
            expect_head("order", kept_codes[i], 1'b0, 1'b0, 4'b0000);
            pop1();
        end
        chk("order_empty", 32'(valid_a), 32'd0);
        drain();

        // reset in the middle of an E0 sequence
        send(8'hE0);
        @(posedge clk); #5 reset = 1'b1;
        @(posedge clk); @(posedge clk); #5 reset = 1'b0;
        @(posedge clk); #1;
        chk("midreset_level", 32'(level_a), 32'd0);
        send(8'h75);
        expect_head("after_reset", 8'h75, 1'b0, 1'b0, 4'b0000);
        drain();

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        repeat (20000) @(posedge clk);
        n_fail++;
        $display("FAIL watchdog: simulation did not finish within cycle budget");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
